// File: rtl/switch_event_detector.sv
// Synchronizes raw switch levels, emits registered edge/change pulses and
// tracks events through a pending/acknowledge handshake with a saturating counter.
module switch_event_detector #(
  parameter int WIDTH       = 3,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [WIDTH-1:0]     i_switch_in,
  input  logic                 i_ack,
  output logic [WIDTH-1:0]     o_switch_sync,
  output logic [WIDTH-1:0]     o_posedge_pulse,
  output logic [WIDTH-1:0]     o_negedge_pulse,
  output logic [WIDTH-1:0]     o_change_pulse,
  output logic                 o_any_event,
  output logic                 o_event_pending,
  output logic [CNT_WIDTH-1:0] o_event_count,
  output logic                 o_missed_event
);

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync_p0;
  logic [WIDTH-1:0]                  r_prev_p1;
  logic [WIDTH-1:0]                  r_pos_p2;
  logic [WIDTH-1:0]                  r_neg_p2;
  logic [WIDTH-1:0]                  r_chg_p2;
  logic [WIDTH-1:0]                  w_sync;
  logic                              w_any;
  state_t                            r_state;
  state_t                            w_next_state;
  logic                              w_set_missed;
  logic [CNT_WIDTH-1:0]              r_count;
  logic                              r_missed;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  assign w_sync = r_sync_p0[SYNC_STAGES-1];
  assign w_any  = |r_chg_p2;

  // Stage p0: synchronizer chain, element 0 samples the raw input
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_sync_p0 <= '0;
    end else begin
      r_sync_p0 <= {r_sync_p0[SYNC_STAGES-2:0], i_switch_in};
    end
  end

  // Stage p1/p2: previous level and registered edge pulses
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_prev_p1 <= '0;
      r_pos_p2  <= '0;
      r_neg_p2  <= '0;
      r_chg_p2  <= '0;
    end else begin
      r_prev_p1 <= w_sync;
      r_pos_p2  <= w_sync & ~r_prev_p1;
      r_neg_p2  <= ~w_sync & r_prev_p1;
      r_chg_p2  <= w_sync ^ r_prev_p1;
    end
  end

  // A new event together with ack replaces the acknowledged one, so it is not a miss
  always_comb begin
    w_next_state = r_state;
    w_set_missed = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) w_next_state = PENDING;
      end
      PENDING: begin
        if (w_any && !i_ack)      w_set_missed = 1'b1;
        else if (!w_any && i_ack) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_missed <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_any)        r_count  <= sat_inc(r_count);
      if (w_set_missed) r_missed <= 1'b1;
    end
  end

  assign o_switch_sync   = w_sync;
  assign o_posedge_pulse = r_pos_p2;
  assign o_negedge_pulse = r_neg_p2;
  assign o_change_pulse  = r_chg_p2;
  assign o_any_event     = w_any;
  assign o_event_pending = (r_state == PENDING);
  assign o_event_count   = r_count;
  assign o_missed_event  = r_missed;

endmodule

// File: tb/tb_switch_event_detector.sv
// Directed bench for switch_event_detector: default instance plus a 2-bit
// counter instance sharing the same stimulus to exercise saturation.
module tb_switch_event_detector;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] sw;
  logic       ack;

  logic [2:0] d_sync, d_pos, d_neg, d_chg;
  logic       d_any, d_pend, d_miss;
  logic [7:0] d_cnt;
  logic [2:0] s_sync, s_pos, s_neg, s_chg;
  logic       s_any, s_pend, s_miss;
  logic [1:0] s_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  switch_event_detector #(.WIDTH(3), .SYNC_STAGES(2), .CNT_WIDTH(8)) dut (
    .i_clock(clk), .i_reset(rst), .i_switch_in(sw), .i_ack(ack),
    .o_switch_sync(d_sync), .o_posedge_pulse(d_pos), .o_negedge_pulse(d_neg),
    .o_change_pulse(d_chg), .o_any_event(d_any), .o_event_pending(d_pend),
    .o_event_count(d_cnt), .o_missed_event(d_miss)
  );

  switch_event_detector #(.WIDTH(3), .SYNC_STAGES(2), .CNT_WIDTH(2)) dut_sat (
    .i_clock(clk), .i_reset(rst), .i_switch_in(sw), .i_ack(ack),
    .o_switch_sync(s_sync), .o_posedge_pulse(s_pos), .o_negedge_pulse(s_neg),
    .o_change_pulse(s_chg), .o_any_event(s_any), .o_event_pending(s_pend),
    .o_event_count(s_cnt), .o_missed_event(s_miss)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; sw = 3'b000; ack = 1'b0;
    #3;
    n_checks++; if (d_cnt !== 8'd0) begin $display("FAIL reset_count got %0d want 0", d_cnt); n_fail++; end
    n_checks++; if (d_pend !== 1'b0) begin $display("FAIL reset_pending got %b want 0", d_pend); n_fail++; end
    n_checks++; if (d_miss !== 1'b0) begin $display("FAIL reset_missed got %b want 0", d_miss); n_fail++; end
    n_checks++; if ({d_sync, d_pos, d_neg, d_chg, d_any} !== 13'd0) begin $display("FAIL reset_pulses got %b want 0", {d_sync, d_pos, d_neg, d_chg, d_any}); n_fail++; end
    n_checks++; if (s_cnt !== 2'd0) begin $display("FAIL reset_sat_count got %0d want 0", s_cnt); n_fail++; end
    tick(); tick();
    rst = 1'b0;
    tick();
    n_checks++; if ({d_chg, d_pend, d_cnt} !== 12'd0) begin $display("FAIL reset_release got %h want 0", {d_chg, d_pend, d_cnt}); n_fail++; end
  endtask

  task automatic test_posedge_detect;
    sw = 3'b001;
    tick();
    n_checks++; if (d_sync !== 3'b000 || d_pos !== 3'b000) begin $display("FAIL pos_e1 sync=%b pos=%b want 000/000", d_sync, d_pos); n_fail++; end
    tick();
    n_checks++; if (d_sync !== 3'b001 || d_pos !== 3'b000) begin $display("FAIL pos_e2 sync=%b pos=%b want 001/000", d_sync, d_pos); n_fail++; end
    tick();
    n_checks++; if (d_pos !== 3'b001 || d_chg !== 3'b001 || d_neg !== 3'b000 || d_any !== 1'b1) begin $display("FAIL pos_e3 pos=%b chg=%b neg=%b any=%b want 001/001/000/1", d_pos, d_chg, d_neg, d_any); n_fail++; end
    n_checks++; if (d_pend !== 1'b0) begin $display("FAIL pos_e3_pend got %b want 0", d_pend); n_fail++; end
    tick();
    n_checks++; if (d_pos !== 3'b000 || d_any !== 1'b0) begin $display("FAIL pos_one_cycle pos=%b any=%b want 000/0", d_pos, d_any); n_fail++; end
    n_checks++; if (d_pend !== 1'b1 || d_cnt !== 8'd1) begin $display("FAIL pos_pending pend=%b cnt=%0d want 1/1", d_pend, d_cnt); n_fail++; end
  endtask

  task automatic test_ack_release;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_checks++; if (d_pend !== 1'b0 || d_cnt !== 8'd1) begin $display("FAIL ack_release pend=%b cnt=%0d want 0/1", d_pend, d_cnt); n_fail++; end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_checks++; if (d_pend !== 1'b0 || d_cnt !== 8'd1) begin $display("FAIL ack_idle pend=%b cnt=%0d want 0/1", d_pend, d_cnt); n_fail++; end
  endtask

  task automatic test_multi_bit;
    sw = 3'b110;
    tick(); tick(); tick();
    n_checks++; if (d_chg !== 3'b111 || d_pos !== 3'b110 || d_neg !== 3'b001 || d_any !== 1'b1) begin $display("FAIL multi_pulse chg=%b pos=%b neg=%b any=%b want 111/110/001/1", d_chg, d_pos, d_neg, d_any); n_fail++; end
    tick();
    n_checks++; if (d_cnt !== 8'd2 || d_pend !== 1'b1) begin $display("FAIL multi_count cnt=%0d pend=%b want 2/1", d_cnt, d_pend); n_fail++; end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_checks++; if (d_pend !== 1'b0) begin $display("FAIL multi_ack pend=%b want 0", d_pend); n_fail++; end
  endtask

  task automatic test_ack_collision;
    sw = 3'b000;
    do_reset();
    sw = 3'b100;
    tick(); tick(); tick();
    n_checks++; if (d_any !== 1'b1 || d_pos !== 3'b100) begin $display("FAIL coll_first any=%b pos=%b want 1/100", d_any, d_pos); n_fail++; end
    tick();
    n_checks++; if (d_pend !== 1'b1 || d_cnt !== 8'd1) begin $display("FAIL coll_pending pend=%b cnt=%0d want 1/1", d_pend, d_cnt); n_fail++; end
    sw = 3'b000;
    tick(); tick(); tick();
    n_checks++; if (d_any !== 1'b1 || d_neg !== 3'b100) begin $display("FAIL coll_second any=%b neg=%b want 1/100", d_any, d_neg); n_fail++; end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_checks++; if (d_pend !== 1'b1 || d_miss !== 1'b0 || d_cnt !== 8'd2) begin $display("FAIL coll_result pend=%b miss=%b cnt=%0d want 1/0/2", d_pend, d_miss, d_cnt); n_fail++; end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_checks++; if (d_pend !== 1'b0) begin $display("FAIL coll_clear pend=%b want 0", d_pend); n_fail++; end
  endtask

  task automatic test_missed_event;
    sw = 3'b001;
    tick(); tick(); tick(); tick();
    n_checks++; if (d_pend !== 1'b1 || d_cnt !== 8'd3) begin $display("FAIL miss_setup pend=%b cnt=%0d want 1/3", d_pend, d_cnt); n_fail++; end
    sw = 3'b000;
    tick(); tick(); tick();
    n_checks++; if (d_neg !== 3'b001 || d_pos !== 3'b000 || d_any !== 1'b1) begin $display("FAIL miss_neg neg=%b pos=%b any=%b want 001/000/1", d_neg, d_pos, d_any); n_fail++; end
    tick();
    n_checks++; if (d_miss !== 1'b1 || d_cnt !== 8'd4 || d_pend !== 1'b1) begin $display("FAIL miss_flag miss=%b cnt=%0d pend=%b want 1/4/1", d_miss, d_cnt, d_pend); n_fail++; end
    n_checks++; if (s_cnt !== 2'd3 || s_miss !== 1'b1) begin $display("FAIL miss_sat cnt=%0d miss=%b want 3/1", s_cnt, s_miss); n_fail++; end
    tick();
    n_checks++; if (d_miss !== 1'b1) begin $display("FAIL miss_sticky miss=%b want 1", d_miss); n_fail++; end
  endtask

  task automatic test_async_reset_midflight;
    sw = 3'b010;
    tick(); tick();
    n_checks++; if (d_pend !== 1'b1 || d_cnt !== 8'd4 || d_sync !== 3'b010) begin $display("FAIL mid_pre pend=%b cnt=%0d sync=%b want 1/4/010", d_pend, d_cnt, d_sync); n_fail++; end
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({d_sync, d_pos, d_neg, d_chg, d_any, d_pend, d_miss} !== 15'd0 || d_cnt !== 8'd0 || s_cnt !== 2'd0) begin $display("FAIL mid_async got %b cnt=%0d want 0", {d_sync, d_pos, d_neg, d_chg, d_any, d_pend, d_miss}, d_cnt); n_fail++; end
    sw = 3'b000;
    #3 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++; if (d_chg !== 3'b000 || d_any !== 1'b0 || d_pend !== 1'b0 || d_cnt !== 8'd0) begin $display("FAIL mid_quiet_%0d chg=%b any=%b pend=%b cnt=%0d want 0", i, d_chg, d_any, d_pend, d_cnt); n_fail++; end
    end
  endtask

  task automatic test_reset_held_high;
    sw = 3'b111;
    do_reset();
    tick();
    n_checks++; if (d_pos !== 3'b000) begin $display("FAIL held_e1 pos=%b want 000", d_pos); n_fail++; end
    tick();
    n_checks++; if (d_sync !== 3'b111 || d_pos !== 3'b000) begin $display("FAIL held_e2 sync=%b pos=%b want 111/000", d_sync, d_pos); n_fail++; end
    tick();
    n_checks++; if (d_pos !== 3'b111 || d_any !== 1'b1) begin $display("FAIL held_pulse pos=%b any=%b want 111/1", d_pos, d_any); n_fail++; end
    tick();
    n_checks++; if (d_cnt !== 8'd1 || d_pend !== 1'b1 || d_pos !== 3'b000) begin $display("FAIL held_count cnt=%0d pend=%b pos=%b want 1/1/000", d_cnt, d_pend, d_pos); n_fail++; end
  endtask

  task automatic test_back_to_back;
    sw = 3'b000;
    do_reset();
    sw = 3'b001; tick();
    sw = 3'b000; tick();
    sw = 3'b001; tick();
    n_checks++; if (d_chg !== 3'b001 || d_pos !== 3'b001) begin $display("FAIL b2b_e3 chg=%b pos=%b want 001/001", d_chg, d_pos); n_fail++; end
    sw = 3'b000; tick();
    n_checks++; if (d_chg !== 3'b001 || d_neg !== 3'b001 || d_cnt !== 8'd1 || s_cnt !== 2'd1) begin $display("FAIL b2b_e4 chg=%b neg=%b cnt=%0d sat=%0d want 001/001/1/1", d_chg, d_neg, d_cnt, s_cnt); n_fail++; end
    sw = 3'b001; tick();
    n_checks++; if (d_pos !== 3'b001 || d_cnt !== 8'd2 || s_cnt !== 2'd2) begin $display("FAIL b2b_e5 pos=%b cnt=%0d sat=%0d want 001/2/2", d_pos, d_cnt, s_cnt); n_fail++; end
    tick();
    n_checks++; if (d_neg !== 3'b001 || d_cnt !== 8'd3 || s_cnt !== 2'd3) begin $display("FAIL b2b_e6 neg=%b cnt=%0d sat=%0d want 001/3/3", d_neg, d_cnt, s_cnt); n_fail++; end
    tick();
    n_checks++; if (d_pos !== 3'b001 || d_cnt !== 8'd4 || s_cnt !== 2'd3) begin $display("FAIL b2b_e7 pos=%b cnt=%0d sat=%0d want 001/4/3", d_pos, d_cnt, s_cnt); n_fail++; end
    tick();
    n_checks++; if (d_chg !== 3'b000 || d_cnt !== 8'd5 || s_cnt !== 2'd3) begin $display("FAIL b2b_e8 chg=%b cnt=%0d sat=%0d want 000/5/3", d_chg, d_cnt, s_cnt); n_fail++; end
  endtask

  initial begin
    test_reset();
    test_posedge_detect();
    test_ack_release();
    test_multi_bit();
    test_ack_collision();
    test_missed_event();
    test_async_reset_midflight();
    test_reset_held_high();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout simulation did not complete within 50000 time units");
    $fatal(1, "timeout");
  end

endmodule
